// File: rtl/ex_mem_if.sv
// EX->MEM handshake bundle for the ex_mem_reg pipeline register.
// slave is the register's view; master is the driver/sink view.
interface ex_mem_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    opcode;
    logic [DW-1:0] alu_out;
    logic [1:0]    flags;
    logic [DW-1:0] st_data;
    logic [RW-1:0] rd;
    logic          reg_we;
    logic          is_branch;
    logic [1:0]    cond;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_opcode;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_st_data;
    logic [RW-1:0] out_rd;
    logic          out_we;
    logic [1:0]    flag_q;
    logic          br_taken;
    logic [DW-1:0] br_target;

    modport slave (
        input  in_valid, opcode, alu_out, flags, st_data, rd,
        input  reg_we, is_branch, cond, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_result,
        output out_st_data, out_rd, out_we, flag_q,
        output br_taken, br_target
    );

    modport master (
        output in_valid, opcode, alu_out, flags, st_data, rd,
        output reg_we, is_branch, cond, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_result,
        input  out_st_data, out_rd, out_we, flag_q,
        input  br_taken, br_target
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with CMP flag register and
// conditional-branch redirect resolved at accept.
module ex_mem_reg #(
    parameter int          DW     = 32,
    parameter int          RW     = 5,
    parameter logic [4:0]  CMP_OP = 5'b10010
) (
    input logic     clk,
    input logic     rst,
    ex_mem_if.slave bus
);
    localparam logic [1:0] C_EQ = 2'b00;
    localparam logic [1:0] C_NE = 2'b01;
    localparam logic [1:0] C_LT = 2'b10;
    localparam logic [1:0] C_GT = 2'b11;

    logic          valid_q, valid_d;
    logic [4:0]    opc_q, opc_d;
    logic [DW-1:0] res_q, res_d;
    logic [DW-1:0] std_q, std_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          we_q, we_d;
    logic [1:0]    flag_q, flag_d;
    logic          brt_q, brt_d;
    logic [DW-1:0] tgt_q, tgt_d;

    logic in_ready;
    logic accept;
    logic is_cmp;
    logic hit;

    assign in_ready = ~valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready & ~bus.flush;
    assign is_cmp   = (bus.opcode == CMP_OP);

    // Condition is judged against the flag register as it stands before this edge
    always_comb begin
        hit = 1'b0;
        case (bus.cond)
            C_EQ:    hit = flag_q[0];
            C_NE:    hit = ~flag_q[0];
            C_LT:    hit = flag_q[1];
            C_GT:    hit = ~flag_q[1] & ~flag_q[0];
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        opc_d   = opc_q;
        res_d   = res_q;
        std_d   = std_q;
        rd_d    = rd_q;
        we_d    = we_q;
        flag_d  = flag_q;
        brt_d   = 1'b0;
        tgt_d   = '0;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            opc_d = bus.opcode;
            res_d = bus.alu_out;
            std_d = bus.st_data;
            rd_d  = bus.rd;
            we_d  = bus.reg_we & ~bus.is_branch & ~is_cmp;
            if (is_cmp) begin
                flag_d = bus.flags;
            end
            if (bus.is_branch & hit) begin
                brt_d = 1'b1;
                tgt_d = bus.alu_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            opc_q   <= '0;
            res_q   <= '0;
            std_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            flag_q  <= 2'b00;
            brt_q   <= 1'b0;
            tgt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            opc_q   <= opc_d;
            res_q   <= res_d;
            std_q   <= std_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            flag_q  <= flag_d;
            brt_q   <= brt_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_opcode  = opc_q;
    assign bus.out_result  = res_q;
    assign bus.out_st_data = std_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_we      = we_q;
    assign bus.flag_q      = flag_q;
    assign bus.br_taken    = brt_q;
    assign bus.br_target   = tgt_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: queue-based model of
// the pipeline register, flag register and branch redirect.
module tb_ex_mem_reg;
    localparam int         DW  = 32;
    localparam int         RW  = 5;
    localparam logic [4:0] CMP = 5'b10010;
    localparam logic [4:0] ADD = 5'b00010;

    typedef struct {
        logic [4:0]    opc;
        logic [DW-1:0] res;
        logic [DW-1:0] std;
        logic [RW-1:0] rd;
        logic          we;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ex_mem_if #(.DW(DW), .RW(RW)) bus ();

    ex_mem_reg #(.DW(DW), .RW(RW), .CMP_OP(CMP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    ent_t          q[$];
    logic [1:0]    mflag   = 2'b00;
    logic          exp_br  = 1'b0;
    logic [DW-1:0] exp_tgt = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    function automatic logic taken(input logic [1:0] c,
                                   input logic [1:0] f);
        logic zero, neg;
        zero = f[0];
        neg  = f[1];
        if (c == 2'b00) return zero;
        if (c == 2'b01) return !zero;
        if (c == 2'b10) return neg;
        return !neg && !zero;
    endfunction

    // Scoreboard: compare visible state, then advance the model
    always @(negedge clk) begin
        logic rdy, acc;
        ent_t e;
        rdy = (q.size() == 0) || bus.out_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("flag_q", 64'(bus.flag_q), 64'(mflag));
        chk("br_taken", 64'(bus.br_taken), 64'(exp_br));
        if (exp_br) chk("br_target", 64'(bus.br_target), 64'(exp_tgt));
        if (q.size() != 0 && bus.out_valid) begin
            chk("out_opcode", 64'(bus.out_opcode), 64'(q[0].opc));
            chk("out_result", 64'(bus.out_result), 64'(q[0].res));
            chk("out_st_data", 64'(bus.out_st_data), 64'(q[0].std));
            chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
            chk("out_we", 64'(bus.out_we), 64'(q[0].we));
        end
        if (rst) begin
            q.delete();
            mflag  = 2'b00;
            exp_br = 1'b0;
        end else begin
            acc = bus.in_valid && rdy && !bus.flush;
            if (bus.flush) q.delete();
            else if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            exp_br  = acc && bus.is_branch && taken(bus.cond, mflag);
            exp_tgt = bus.alu_out;
            if (acc) begin
                e.opc = bus.opcode;
                e.res = bus.alu_out;
                e.std = bus.st_data;
                e.rd  = bus.rd;
                e.we  = bus.reg_we && !bus.is_branch && bus.opcode != CMP;
                q.push_back(e);
                if (bus.opcode == CMP) mflag = bus.flags;
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] op,
                       input logic [DW-1:0] a, input logic [1:0] f,
                       input logic br, input logic [1:0] c,
                       input logic fl, input logic rdy,
                       input logic r);
        rst           = r;
        bus.in_valid  = v;
        bus.opcode    = op;
        bus.alu_out   = a;
        bus.flags     = f;
        bus.st_data   = $urandom;
        bus.rd        = RW'($urandom);
        bus.reg_we    = 1'b1;
        bus.is_branch = br;
        bus.cond      = c;
        bus.flush     = fl;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_opcode", 64'(bus.out_opcode), 64'd0);
        chk("rst_target", 64'(bus.br_target), 64'd0);
        chk("rst_we", 64'(bus.out_we), 64'd0);
        @(posedge clk);
        #1;
        // 1: ADD with rd=3
        rst = 0;
        bus.in_valid = 1; bus.opcode = ADD; bus.alu_out = 32'h1234;
        bus.flags = 0; bus.st_data = 0; bus.rd = 3; bus.reg_we = 1;
        bus.is_branch = 0; bus.cond = 0; bus.flush = 0;
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        // 2: CMP Z=1 then EQ branch
        cyc(1, CMP, 32'h99, 2'b01, 0, 0, 0, 1, 0);
        cyc(1, ADD, 32'h40, 2'b00, 1, 2'b00, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // 3: N=1, GT branch not taken
        cyc(1, CMP, 32'h5, 2'b10, 0, 0, 0, 1, 0);
        cyc(1, ADD, 32'h80, 2'b00, 1, 2'b11, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // 4: stall five cycles then drain back-to-back
        cyc(1, ADD, 32'hA1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(1, ADD, 32'hB0 + DW'(i), 0, 0, 0, 0, 0, 0);
        cyc(1, ADD, 32'hC1, 0, 0, 0, 0, 1, 0);
        cyc(1, ADD, 32'hC2, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // 5: flush with a held entry and incoming entry
        cyc(1, ADD, 32'hD1, 0, 0, 0, 0, 0, 0);
        cyc(1, ADD, 32'hD2, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // flush racing out_ready
        cyc(1, ADD, 32'hD3, 0, 0, 0, 0, 0, 0);
        cyc(1, ADD, 32'hD4, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // 6: reset during a stall
        cyc(1, CMP, 32'hE1, 2'b11, 0, 0, 0, 0, 0);
        cyc(1, ADD, 32'hE2, 0, 0, 0, 0, 0, 0);
        cyc(1, ADD, 32'hE3, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? CMP : 5'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), op, $urandom,
                2'($urandom), 1'($urandom_range(0, 3) == 0),
                2'($urandom), 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 99) == 0));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
